mux_rr_arbiter: RTL and testbench

Round-robin packet arbiter that shares one output channel among N requesters by sequencing the select of an N:1 data mux. Each requester presents valid/data/last beats. The arbiter locks onto one requester for a whole packet (through the beat with last=1), then rotates priority. It sits in front of the 16:1 mux datapath and drives its select, so the mux tree is time-shared with fair, packet-atomic access.

---
 rtl/mux_rr_arbiter.sv | 149 ++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mux_rr_arbiter
//   Round-robin packet arbiter driving the select of an N:1 data mux. A
//   requester is locked for a whole packet (through its last beat). Priority
//   then rotates to the index after the one just served. The output beat is
//   registered and can be stalled by out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   [N]      per-requester beat valid
//   in_ready   [N]      per-requester beat accept (one-hot or zero)
//   in_data    [N*DW]   requester i on bits [i*DW +: DW]
//   in_last    [N]      per-requester end-of-packet flag
//   out_valid           registered output beat valid
//   out_ready           downstream accept
//   out_data   [DW]     registered muxed data
//   out_last            registered last flag of the beat
//   out_sel    [SELW]   requester that supplied the current output beat
//   busy                high while a packet is locked
// -----------------------------------------------------------------------------
module mux_rr_arbiter #(
    parameter int N  = 16,
    parameter int DW = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      in_valid,
    output logic [N-1:0]      in_ready,
    input  logic [N*DW-1:0]   in_data,
    input  logic [N-1:0]      in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic [SELW-1:0]   out_sel,
    output logic              busy
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [SELW-1:0]   r_grant;
    logic [SELW-1:0]   w_grant_nxt;
    logic [SELW-1:0]   r_ptr;
    logic [SELW-1:0]   w_ptr_nxt;

    logic              r_out_valid;
    logic [DW-1:0]     r_out_data;
    logic              r_out_last;
    logic [SELW-1:0]   r_out_sel;

    logic              w_found;
    logic [SELW-1:0]   w_pick;
    logic              w_accept;
    logic              w_xfer;

    // Round-robin scan: first valid index starting at r_ptr and wrapping.
    always_comb begin : p_pick
        int unsigned idx;
        w_found = 1'b0;
        w_pick  = '0;
        idx     = 0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = 32'(r_ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!w_found && in_valid[idx]) begin
                w_found = 1'b1;
                w_pick  = SELW'(idx);
            end
        end
    end

    // The output register can take a new beat when empty or being drained.
    assign w_accept = ~r_out_valid | out_ready;
    assign w_xfer   = (r_state == ST_LOCK) & w_accept & in_valid[r_grant];

    always_comb begin
        in_ready = '0;
        if (r_state == ST_LOCK) begin
            in_ready[r_grant] = w_accept;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_LOCK;
                    w_grant_nxt = w_pick;
                end
            end
            ST_LOCK: begin
                if (w_xfer && in_last[r_grant]) begin
                    w_state_nxt = ST_IDLE;
                    w_ptr_nxt   = (r_grant == SELW'(N - 1)) ? '0 : r_grant + SELW'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Output beat register: load on transfer, clear valid when drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_sel   <= '0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= in_data[r_grant*DW +: DW];
            r_out_last  <= in_last[r_grant];
            r_out_sel   <= r_grant;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_sel   = r_out_sel;
    assign busy      = (r_state == ST_LOCK);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_arbiter
//   Directed bench for mux_rr_arbiter (N=16, DW=8). Inputs change 1 ns after
//   the rising edge; registered outputs are checked there, and combinational
//   in_ready is checked 1 ns after the inputs settle.
// -----------------------------------------------------------------------------
module tb_mux_rr_arbiter;

    logic         clk;
    logic         rst_n;
    logic [15:0]  in_valid;
    logic [15:0]  in_ready;
    logic [127:0] in_data;
    logic [15:0]  in_last;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_data;
    logic         out_last;
    logic [3:0]   out_sel;
    logic         busy;

    int tests = 0;
    int fails = 0;

    mux_rr_arbiter #(.N(16), .DW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_sel   (out_sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                           input logic l, input logic [3:0] s);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".last"},  32'(out_last),  32'(l));
        check({tag, ".sel"},   32'(out_sel),   32'(s));
    endtask

    task automatic chk_ctl(input string tag, input logic [15:0] rdy, input logic b);
        check({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        check({tag, ".busy"},     32'(busy),     32'(b));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        in_valid[i]      = v;
        in_data[i*8 +: 8] = d;
        in_last[i]       = l;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        in_last   = '0;
        out_ready = 1'b1;

        // ---------------- reset / idle ----------------
        repeat (3) tick();
        chk_out("rst", 1'b0, 8'h00, 1'b0, 4'd0);
        chk_ctl("rst", 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) tick();
        chk_out("idle", 1'b0, 8'h00, 1'b0, 4'd0);
        chk_ctl("idle", 16'h0000, 1'b0);

        // ---------------- single requester 3 ----------------
        set_req(3, 1'b1, 8'hA1, 1'b0);
        tick();                                 // arbitration edge
        chk_ctl("s3.lock", 16'h0008, 1'b1);
        chk_out("s3.lock", 1'b0, 8'h00, 1'b0, 4'd0);
        tick();                                 // 2 cycles after in_valid
        chk_out("s3.b0", 1'b1, 8'hA1, 1'b0, 4'd3);
        set_req(3, 1'b1, 8'hA2, 1'b0);
        #1 chk_ctl("s3.b1", 16'h0008, 1'b1);
        tick();
        chk_out("s3.b1", 1'b1, 8'hA2, 1'b0, 4'd3);
        set_req(3, 1'b1, 8'hA3, 1'b1);
        tick();
        chk_out("s3.b2", 1'b1, 8'hA3, 1'b1, 4'd3);
        chk_ctl("s3.end", 16'h0000, 1'b0);
        set_req(3, 1'b0, 8'h00, 1'b0);

        // ptr is now 4: with 2 and 4 both requesting, 4 must win
        set_req(2, 1'b1, 8'h2B, 1'b1);
        set_req(4, 1'b1, 8'h4B, 1'b1);
        tick();
        chk_ctl("ptr4.grant", 16'h0010, 1'b1);
        check("ptr4.drain", 32'(out_valid), 32'd0);
        tick();
        chk_out("ptr4.beat", 1'b1, 8'h4B, 1'b1, 4'd4);
        set_req(4, 1'b0, 8'h00, 1'b0);
        tick();
        chk_ctl("ptr5.grant", 16'h0004, 1'b1);
        tick();
        chk_out("ptr5.beat", 1'b1, 8'h2B, 1'b1, 4'd2);
        set_req(2, 1'b0, 8'h00, 1'b0);
        tick();

        // ---------------- round robin 0/5/15 from ptr 0 ----------------
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0,  1'b1, 8'h00, 1'b1);
        set_req(5,  1'b1, 8'h05, 1'b1);
        set_req(15, 1'b1, 8'h0F, 1'b1);
        tick();
        chk_ctl("rr.g0", 16'h0001, 1'b1);
        tick();
        chk_out("rr.o0", 1'b1, 8'h00, 1'b1, 4'd0);
        chk_ctl("rr.gap0", 16'h0000, 1'b0);
        tick();
        chk_ctl("rr.g5", 16'h0020, 1'b1);
        check("rr.gap0.ov", 32'(out_valid), 32'd0);
        tick();
        chk_out("rr.o5", 1'b1, 8'h05, 1'b1, 4'd5);
        tick();
        chk_ctl("rr.g15", 16'h8000, 1'b1);
        tick();
        chk_out("rr.o15", 1'b1, 8'h0F, 1'b1, 4'd15);
        tick();
        chk_ctl("rr.wrap0", 16'h0001, 1'b1);
        tick();
        chk_out("rr.o0b", 1'b1, 8'h00, 1'b1, 4'd0);
        tick();
        chk_ctl("rr.g5b", 16'h0020, 1'b1);
        tick();
        chk_out("rr.o5b", 1'b1, 8'h05, 1'b1, 4'd5);
        in_valid = '0;
        in_last  = '0;
        tick();                                 // ptr now 6, idle

        // ---------------- packet atomicity: req 2 vs req 1 ----------------
        set_req(2, 1'b1, 8'h20, 1'b0);
        tick();
        set_req(1, 1'b1, 8'h11, 1'b1);
        #1 chk_ctl("at.lock", 16'h0004, 1'b1);
        tick();
        chk_out("at.b0", 1'b1, 8'h20, 1'b0, 4'd2);
        set_req(2, 1'b1, 8'h21, 1'b0);
        #1 chk_ctl("at.b1", 16'h0004, 1'b1);
        tick();
        chk_out("at.b1", 1'b1, 8'h21, 1'b0, 4'd2);
        set_req(2, 1'b0, 8'h21, 1'b0);          // requester 2 pauses
        tick();
        check("at.gap1.ov", 32'(out_valid), 32'd0);
        chk_ctl("at.gap1", 16'h0004, 1'b1);
        tick();
        check("at.gap2.ov", 32'(out_valid), 32'd0);
        chk_ctl("at.gap2", 16'h0004, 1'b1);
        set_req(2, 1'b1, 8'h22, 1'b0);
        tick();
        chk_out("at.b2", 1'b1, 8'h22, 1'b0, 4'd2);
        set_req(2, 1'b1, 8'h23, 1'b1);
        tick();
        chk_out("at.b3", 1'b1, 8'h23, 1'b1, 4'd2);
        chk_ctl("at.end", 16'h0000, 1'b0);
        set_req(2, 1'b0, 8'h00, 1'b0);
        tick();
        chk_ctl("at.g1", 16'h0002, 1'b1);
        tick();
        chk_out("at.o1", 1'b1, 8'h11, 1'b1, 4'd1);
        set_req(1, 1'b0, 8'h00, 1'b0);

        // ---------------- backpressure on req 9 ----------------
        set_req(9, 1'b1, 8'h90, 1'b0);
        tick();
        chk_ctl("bp.lock", 16'h0200, 1'b1);
        tick();
        chk_out("bp.b0", 1'b1, 8'h90, 1'b0, 4'd9);
        set_req(9, 1'b1, 8'h91, 1'b0);
        tick();
        chk_out("bp.b1", 1'b1, 8'h91, 1'b0, 4'd9);
        set_req(9, 1'b1, 8'h92, 1'b0);
        out_ready = 1'b0;
        #1 chk_ctl("bp.stall", 16'h0000, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk_out("bp.hold", 1'b1, 8'h91, 1'b0, 4'd9);
            check("bp.hold.rdy", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        #1 chk_ctl("bp.resume", 16'h0200, 1'b1);
        tick();
        chk_out("bp.b2", 1'b1, 8'h92, 1'b0, 4'd9);
        set_req(9, 1'b1, 8'h93, 1'b1);
        tick();
        chk_out("bp.b3", 1'b1, 8'h93, 1'b1, 4'd9);
        set_req(9, 1'b0, 8'h00, 1'b0);
        tick();
        chk_out("bp.drain", 1'b0, 8'h93, 1'b1, 4'd9);
        chk_ctl("bp.drain", 16'h0000, 1'b0);

        // ---------------- reset mid-packet on req 7 ----------------
        set_req(7, 1'b1, 8'h70, 1'b0);
        tick();
        chk_ctl("mr.lock", 16'h0080, 1'b1);
        tick();
        chk_out("mr.b0", 1'b1, 8'h70, 1'b0, 4'd7);
        set_req(7, 1'b1, 8'h71, 1'b0);
        #2 rst_n = 1'b0;                        // asynchronous, mid-cycle
        #1;
        chk_out("mr.rst", 1'b0, 8'h00, 1'b0, 4'd0);
        chk_ctl("mr.rst", 16'h0000, 1'b0);
        tick();
        chk_out("mr.rsthold", 1'b0, 8'h00, 1'b0, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_req(0, 1'b1, 8'h0A, 1'b1);
        tick();
        chk_ctl("mr.g0", 16'h0001, 1'b1);
        check("mr.nobeat", 32'(out_valid), 32'd0);
        tick();
        chk_out("mr.o0", 1'b1, 8'h0A, 1'b1, 4'd0);
        in_valid = '0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Safety net: the directed sequence is bounded, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
